// File: rtl/seq_add_pkg.sv
// seq_add_pkg: shared constants and FSM encoding for the bit-serial adder.
//   DEFAULT_WIDTH : default operand width in bits
//   state_t       : controller state encoding (2'b11 left unused)
package seq_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : seq_add_pkg

// File: rtl/seq_add_ctrl_full_addr.sv
// half_addr / full_addr: combinational 1-bit adder cells for the serial adder.
//   half_addr : in1, in2        -> out (sum), cout (carry)
//   full_addr : in1, in2, cin   -> out (sum), cout (carry)
// full_addr is two chained half adders with their carries ORed.
module half_addr (
    input  logic in1,
    input  logic in2,
    output logic out,
    output logic cout
);

    assign out  = in1 ^ in2;
    assign cout = in1 & in2;

endmodule : half_addr

module full_addr (
    input  logic in1,
    input  logic in2,
    input  logic cin,
    output logic out,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_addr u_ha0 (
        .in1  (in1),
        .in2  (in2),
        .out  (s0),
        .cout (c0)
    );

    half_addr u_ha1 (
        .in1  (s0),
        .in2  (cin),
        .out  (out),
        .cout (c1)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign cout = c0 | c1;

endmodule : full_addr

// File: rtl/seq_add_ctrl.sv
// seq_add_ctrl: bit-serial adder, one full-adder cell sequenced LSB first
// over WIDTH cycles.
//   clk, rst_n    : clock, synchronous active-low reset
//   start         : begin an addition (sampled only in IDLE)
//   a, b          : operands (latched on the accepted start)
//   sub           : subtract request, present only with SEQ_ADD_SUB_EN defined
//   sum, cout     : registered result and carry out, updated at RUN->DONE
//   busy          : high while in RUN
//   done          : one-cycle pulse while in DONE
// Build option: define SEQ_ADD_SUB_EN to add the sub port (a - b mode).
module seq_add_ctrl
    import seq_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SEQ_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             sub_c;
    logic             last_c;
    logic             busy_nx;
    logic             done_nx;

`ifdef SEQ_ADD_SUB_EN
    assign sub_c = sub;
`else
    assign sub_c = 1'b0;
`endif

    assign last_c = (cnt == CNT_W'(WIDTH - 1));

    // Single adder cell fed by the operand LSBs and the running carry.
    full_addr u_fa (
        .in1  (a_sh[0]),
        .in2  (b_sh[0]),
        .cin  (carry),
        .out  (fa_sum),
        .cout (fa_cout)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_nx = state;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_c) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == RUN);
        done_nx = (state_nx == DONE);
    end

    // State register, datapath and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= busy_nx;
            done  <= done_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtract is a + ~b + 1: invert b, preset the carry.
                        a_sh   <= a;
                        b_sh   <= sub_c ? ~b : b;
                        carry  <= sub_c;
                        cnt    <= '0;
                        res_sh <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
                    carry  <= fa_cout;
                    // Counter holds at WIDTH-1 on the last bit so it never wraps.
                    if (!last_c) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    if (last_c) begin
                        sum  <= {fa_sum, res_sh[WIDTH-1:1]};
                        cout <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : seq_add_ctrl

// File: tb/tb_seq_add_ctrl.sv
// tb_seq_add_ctrl: self-checking bench for seq_add_ctrl (WIDTH=8), directed
// cases plus randomized operations against an arithmetic reference model.
module tb_seq_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub_r;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    int errors;
    int checks;

    logic [W-1:0] exp_sum;
    logic         exp_cout;

    seq_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef SEQ_ADD_SUB_EN
        .sub   (sub_r),
`endif
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {cout, sum} from plain unsigned arithmetic.
    function automatic logic [W:0] model(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                         input logic os);
        int unsigned ia;
        int unsigned ib;
        ia = 32'(oa);
        ib = 32'(ob);
        if (os) begin
            return {(ia >= ib) ? 1'b1 : 1'b0, W'((ia - ib) % 256)};
        end
        return (W+1)'(ia + ib);
    endfunction

    function automatic logic rand_sub();
`ifdef SEQ_ADD_SUB_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    // One full operation with start/operand noise during RUN and DONE.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os,
                          input string tag);
        logic [W:0] r;
        r = model(oa, ob, os);
        a = oa;
        b = ob;
        sub_r = os;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub_r = rand_sub();
        check({tag, " busy_at_accept"}, 32'(busy), 32'd1);
        for (int i = 1; i <= int'(W); i++) begin
            if (i < int'(W)) start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (i < int'(W)) begin
                check({tag, " busy_run"}, 32'(busy), 32'd1);
                check({tag, " done_run"}, 32'(done), 32'd0);
                check({tag, " sum_hold"}, 32'(sum), 32'(exp_sum));
            end
        end
        check({tag, " done_pulse"}, 32'(done), 32'd1);
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(r[W-1:0]));
        check({tag, " cout"}, 32'(cout), 32'(r[W]));
        exp_sum = r[W-1:0];
        exp_cout = r[W];
        start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done_clear"}, 32'(done), 32'd0);
        check({tag, " busy_idle"}, 32'(busy), 32'd0);
        check({tag, " sum_idle"}, 32'(sum), 32'(exp_sum));
    endtask

    initial begin
        int cyc;
        int d1;
        int d2;
        int seen_done;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        sub_r = 1'b0;
        exp_sum = '0;
        exp_cout = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start", 32'(busy), 32'd0);

        // Directed additions.
        run_op(8'h05, 8'h03, 1'b0, "add_05_03");
        run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
        run_op(8'h80, 8'h80, 1'b0, "add_80_80");
        run_op(8'h00, 8'h00, 1'b0, "add_00_00");
`ifdef SEQ_ADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, "sub_05_07");
        run_op(8'h07, 8'h05, 1'b1, "sub_07_05");
        run_op(8'h42, 8'h42, 1'b1, "sub_eq");
`endif

        // start held high; operands change mid-RUN.
        a = 8'h21;
        b = 8'h42;
        sub_r = 1'b0;
        start = 1'b1;
        cyc = 0;
        d1 = -1;
        d2 = -1;
        while (d2 < 0 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 3) begin
                a = 8'h9C;
                b = 8'h7A;
            end
            if (done) begin
                if (d1 < 0) begin
                    d1 = cyc;
                    check("hold first_sum", 32'(sum), 32'h63);
                    check("hold first_cout", 32'(cout), 32'd0);
                end else begin
                    d2 = cyc;
                    check("hold second_sum", 32'(sum), 32'h16);
                    check("hold second_cout", 32'(cout), 32'd1);
                end
            end
        end
        start = 1'b0;
        check("hold first_latency", 32'(d1), 32'd9);
        check("hold done_gap", 32'(d2 - d1), 32'd10);
        exp_sum = 8'h16;
        exp_cout = 1'b1;
        @(posedge clk); #1;
        check("hold back_idle", 32'(busy), 32'd0);

        // Reset during the 4th RUN cycle.
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid no_edge_sum", 32'(sum), 32'(exp_sum));
        check("rst_mid no_edge_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid done", 32'(done), 32'd0);
        check("rst_mid sum", 32'(sum), 32'd0);
        check("rst_mid cout", 32'(cout), 32'd0);
        exp_sum = '0;
        exp_cout = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        check("rst_mid no_done", 32'(seen_done), 32'd0);
        run_op(8'h33, 8'h11, 1'b0, "after_rst");

        // Randomized operations.
        for (int n = 0; n < 24; n++) begin
            run_op(W'($urandom), W'($urandom), rand_sub(), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_add_ctrl

// File: doc/seq_add_ctrl.md
SEQ_ADD_CTRL -- requirements
Module: seq_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each, the operands; sampled only on the accepted start.
REQ-006 The block SHALL have port sum, output, WIDTH bits, the registered result.
REQ-007 The block SHALL have port cout, output, 1 bit, the registered carry out of the MSB.
REQ-008 The block SHALL have port busy, output, 1 bit, high while in RUN.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse when sum and cout become valid.

Function
REQ-010 The block SHALL sequence one 1-bit full-adder cell over WIDTH cycles, LSB first, to add a and b (bit-serial adder).
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 IDLE with start=1 SHALL latch a and b into shift registers, clear the carry flop, clear the bit counter, and go to RUN; start=0 stays in IDLE.
REQ-013 Each RUN cycle SHALL feed operand LSBs and the carry flop to the cell, shift the cell sum into the result MSB, shift both operands right, update the carry flop, and increment the counter.
REQ-014 RUN SHALL exit to DONE after exactly WIDTH cycles (counter reaches WIDTH-1 on the last cycle); the counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap inside one operation.
REQ-015 On entry to DONE, sum SHALL equal (a+b) mod 2^WIDTH and cout SHALL equal bit WIDTH of a+b.
REQ-016 done SHALL be high for exactly the one cycle spent in DONE; DONE SHALL always return to IDLE on the next cycle.
REQ-017 Latency: start accepted at edge t -> done high in the cycle after edge t+WIDTH; the next start can be accepted at edge t+WIDTH+2.
REQ-018 sum and cout SHALL hold their last valid values in IDLE until the next accepted start; they SHALL be updated only at the RUN->DONE transition, with no intermediate partial values visible.
REQ-019 start asserted in RUN or DONE SHALL be ignored, with no queuing; changes to a or b after acceptance SHALL NOT affect the result.
REQ-020 busy SHALL be high in RUN only, and low in IDLE and DONE.

Reset
REQ-021 rst_n=0 at a rising edge SHALL force IDLE, with sum=0, cout=0, busy=0, done=0, and carry, counter and operand registers cleared.
REQ-022 Reset SHALL take priority over start and SHALL abort an operation in RUN or DONE without asserting done.
REQ-023 With rst_n low and no clock edge, outputs SHALL keep their values (synchronous reset only).

Configuration
REQ-024 Macro SEQ_ADD_SUB_EN, when defined, SHALL add an input port sub (1 bit, sampled with start).
REQ-025 With sub=1, the block SHALL invert the latched b and preset the carry flop to 1, giving sum=(a-b) mod 2^WIDTH and cout=1 iff a>=b (unsigned); with sub=0, behaviour SHALL be as REQ-015.
REQ-026 Without SEQ_ADD_SUB_EN, the sub port SHALL NOT exist and the block SHALL add only; latency SHALL be identical in both builds.

Structure
REQ-027 The state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant SHALL live in shared package seq_add_pkg.
REQ-028 The 1-bit cell SHALL be a separate combinational sub-module full_addr (in1, in2, cin -> out, cout), built from two half-adder instances plus an OR.
REQ-029 The encoding SHALL leave 2'b11 unused; an unused encoding SHALL return to IDLE on the next edge.

Verification (WIDTH=8)
REQ-030 The bench SHALL check: a=8'h05, b=8'h03, start pulse -> busy for 8 cycles, then done pulse with sum=8'h08, cout=0; done 9 cycles after the start edge.
REQ-031 The bench SHALL check: a=8'hFF, b=8'h01 -> sum=8'h00, cout=1; a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
REQ-032 The bench SHALL check: start held high continuously with a and b changed mid-RUN -> the first result reflects the latched operands, the next start is accepted only in IDLE, and done pulses are separated by 10 cycles.
REQ-033 The bench SHALL check: rst_n=0 for one edge in the 4th RUN cycle -> next cycle IDLE, sum=0, cout=0, busy=0, no done pulse; a new start then completes normally.
REQ-034 The bench SHALL check, with SEQ_ADD_SUB_EN defined: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0; a=8'h07, b=8'h05, sub=1 -> sum=8'h02, cout=1.
